// File: rtl/alu_result_serializer.sv
// ---------------------------------------------------------------------------
// alu_result_serializer
//
// Downstream stage of the ALU. Each registered ALU result (ALU_OUT qualified
// by OUT_VALID) is split into BYTE_W-wide bytes and pushed, least-significant
// byte first, into the UART TX FIFO over a valid/full handshake. One result
// is in flight (shadow) and one more can wait in a one-deep pending slot, so
// back-to-back ALU results are not lost. A result arriving while both slots
// are occupied is dropped and flagged on OVERRUN.
//
// Ports
//   CLK        in   1       clock
//   RST        in   1       asynchronous, active-low reset
//   ALU_OUT    in   OUT_W   ALU result, valid when OUT_VALID=1
//   OUT_VALID  in   1       one-cycle strobe per result
//   FIFO_FULL  in   1       TX FIFO full; byte moves when TX_D_VLD & ~FIFO_FULL
//   TX_P_DATA  out  BYTE_W  byte offered to the TX FIFO
//   TX_D_VLD   out  1       TX_P_DATA valid
//   BUSY       out  1       result in flight or pending
//   OVERRUN    out  1       one-cycle pulse when an incoming result is dropped
// ---------------------------------------------------------------------------
module alu_result_serializer #(
    parameter int OUT_W  = 16,
    parameter int BYTE_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [OUT_W-1:0]  ALU_OUT,
    input  logic              OUT_VALID,
    input  logic              FIFO_FULL,
    output logic [BYTE_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    output logic              BUSY,
    output logic              OVERRUN
);

    localparam int NBYTES = OUT_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [OUT_W-1:0]  shadow;
    logic [OUT_W-1:0]  pend;
    logic              pend_vld;
    logic [IDX_W-1:0]  idx;
    logic              overrun;

    logic acc;
    logic last;

    // Handshake qualifiers depend only on flops plus FIFO_FULL; they steer
    // state updates but never feed the outputs.
    assign acc  = (state == SEND) && !FIFO_FULL;
    assign last = acc && (idx == LAST_IDX);

    // Outputs decode purely from registered state.
    assign TX_D_VLD  = (state == SEND);
    assign TX_P_DATA = (state == SEND) ? shadow[idx*BYTE_W +: BYTE_W] : '0;
    assign BUSY      = (state == SEND) || pend_vld;
    assign OVERRUN   = overrun;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            shadow   <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            idx      <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (OUT_VALID) begin
                        shadow <= ALU_OUT;
                        idx    <= '0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (last) begin
                        idx <= '0;
                        if (pend_vld) begin
                            // Pending result moves up with no bubble; an
                            // arrival on this edge refills the freed slot.
                            shadow <= pend;
                            if (OUT_VALID) begin
                                pend <= ALU_OUT;
                            end else begin
                                pend_vld <= 1'b0;
                            end
                        end else if (OUT_VALID) begin
                            shadow <= ALU_OUT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (acc) begin
                            idx <= idx + 1'b1;
                        end
                        if (OUT_VALID) begin
                            if (!pend_vld) begin
                                pend     <= ALU_OUT;
                                pend_vld <= 1'b1;
                            end else begin
                                // Both slots occupied: drop the arrival.
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
